ej32_ss_ctl: RTL
================

EJ32_SS_CTL -- requirements
Module: ej32_ss_ctl

Interface
REQ-001 Parameter SS_DEPTH, default 32: maximum data stack entries, NOS included; power of two, at least 4.
REQ-002 Parameter DSZ, default 32: data word width.
REQ-003 Constant SPW = $clog2(SS_DEPTH)+1 is the depth counter width; the default is 6.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  stack enable; when low, ss_op is treated as sNOP.
REQ-007 ss_op  in  2  stack op of type ss_op_t: sNOP, sPOP, sPUSH or sMOVE.
REQ-008 t  in  DSZ  current TOS value from the control bus.
REQ-009 clr_err  in  1  synchronous clear of the ovf_o and unf_o flags.
REQ-010 s_o  out  DSZ  NOS; registered output.
REQ-011 sp_o  out  SPW  current depth d, 0..SS_DEPTH.
REQ-012 bsy_o  out  1  fill in progress; the requester holds its op while this is high.
REQ-013 ovf_o  out  1  sticky overflow flag.
REQ-014 unf_o  out  1  sticky underflow flag.

Function
REQ-015 NOS shall be held in register s_r; entries below NOS shall live in sub-module ej32_ss_ram, where entry k is stored at address k.
REQ-016 Invariant: the RAM holds max(d-1, 0) valid words; s_r is valid when d >= 1 and reads 0 when d = 0.
REQ-017 FSM states: IDLE and FILL. Reset enters IDLE. Only a POP with d >= 2 goes IDLE -> FILL. FILL returns to IDLE unconditionally after 1 cycle.
REQ-018 bsy_o shall be 1 exactly while in FILL; any op presented in FILL shall be ignored, with no state, flag or RAM change.
REQ-019 PUSH in IDLE with 1 <= d < SS_DEPTH: write s_r to RAM[d-1]; s_r <= t; d <= d+1; single cycle; bsy_o stays 0.
REQ-020 PUSH in IDLE with d = 0: s_r <= t and d <= 1; no RAM write.
REQ-021 PUSH in IDLE with d = SS_DEPTH: ovf_o <= 1; d, s_r and RAM unchanged.
REQ-022 POP in IDLE with d >= 2: issue a read of RAM[d-2]; d <= d-1 in the same cycle; next state FILL.
REQ-023 In FILL, s_r <= RAM read data, giving 1 cycle of read latency.
REQ-024 POP in IDLE with d = 1: s_r <= 0 and d <= 0; no read, no FILL.
REQ-025 POP in IDLE with d = 0: unf_o <= 1; all other state unchanged.
REQ-026 MOVE in IDLE with d >= 1: s_r <= t; d unchanged; single cycle.
REQ-027 MOVE in IDLE with d = 0: unf_o <= 1; no other change.
REQ-028 The RAM shall perform at most one access (read or write) per cycle; no op ever requires both.
REQ-029 clr_err clears ovf_o and unf_o; if it coincides with a new error event, the set wins.
REQ-030 s_o shall equal s_r at all times; sp_o shall equal d at all times.

Reset
REQ-031 On rst asserted: d = 0, s_r = 0, state IDLE, ovf_o = 0, unf_o = 0, bsy_o = 0, s_o = 0, sp_o = 0.
REQ-032 Reset during FILL shall abort the fill with no s_r update; the next cycle is IDLE with d = 0.
REQ-033 RAM contents need not be reset; no behaviour shall depend on them.

Structure
REQ-034 The ss_op_t enum (sNOP, sPOP, sPUSH, sMOVE) shall live in the shared package ej32_pkg.
REQ-035 The SS_DEPTH and DSZ defaults shall be package constants in ej32_pkg.
REQ-036 Sub-module ej32_ss_ram: single-port synchronous RAM, SS_DEPTH-1 words by DSZ bits, 1-cycle read latency, EBR-inferable, with ports clk, we, addr, wd and rd.
REQ-037 All control logic (FSM, depth counter, flags) shall be in ej32_ss_ctl; no logic shall be placed inside the RAM wrapper.

Verification
REQ-038 From reset, PUSH 0x11, 0x22, 0x33 -> sp_o = 3, s_o = 0x33, bsy_o never high.
REQ-039 Then POP -> bsy_o = 1 for exactly 1 cycle, then s_o = 0x22 and sp_o = 2; a second POP gives s_o = 0x11; a third POP gives s_o = 0 and sp_o = 0 with no busy cycle.
REQ-040 From d = 0, POP and then MOVE -> unf_o = 1, sp_o stays 0; clr_err -> unf_o = 0.
REQ-041 Push values 1..32, then a 33rd PUSH of 0xDEAD -> ovf_o = 1, sp_o = 32, s_o = 32; 31 POPs then return s_o = 31..1 in order.
REQ-042 With d = 3, POP, and in the FILL cycle present PUSH 0x99 -> PUSH ignored, s_o = old RAM[1], sp_o = 2.
REQ-043 With d = 4, POP with rst asserted during FILL -> sp_o = 0, s_o = 0, bsy_o = 0 next cycle; a following PUSH 0x5 gives s_o = 5, sp_o = 1.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared EJ32 definitions: stack op encoding, FSM state type and
// default sizing for the second-stack controller.
package ej32_pkg;

  localparam int SS_DEPTH_DEF = 32;
  localparam int DSZ_DEF      = 32;

  typedef enum logic [1:0] {
    sNOP  = 2'd0,
    sPOP  = 2'd1,
    sPUSH = 2'd2,
    sMOVE = 2'd3
  } ss_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } ss_state_t;

endpackage

// File: rtl/ej32_ss_ram.sv
// Single-port synchronous RAM holding the stack entries below NOS.
// One-cycle registered read, suitable for block-RAM inference.
module ej32_ss_ram
  import ej32_pkg::*;
#(
  parameter int SS_DEPTH = SS_DEPTH_DEF,
  parameter int DSZ      = DSZ_DEF,
  localparam int AW      = $clog2(SS_DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  addr,
  input  logic [DSZ-1:0] wd,
  output logic [DSZ-1:0] rd
);

  logic [DSZ-1:0] r_mem [0:SS_DEPTH-2];

  // Write on we; registered read of the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wd;
    rd <= r_mem[addr];
  end

endmodule

// File: rtl/ej32_ss_ctl.sv
// Data-stack controller: NOS kept in a register, deeper entries in a
// single-port RAM. A POP that needs a refill from RAM spends one FILL
// cycle waiting for the read data, during which bsy_o is high.
module ej32_ss_ctl
  import ej32_pkg::*;
#(
  parameter int SS_DEPTH = SS_DEPTH_DEF,
  parameter int DSZ      = DSZ_DEF,
  localparam int SPW     = $clog2(SS_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  ss_op_t         ss_op,
  input  logic [DSZ-1:0] t,
  input  logic           clr_err,
  output logic [DSZ-1:0] s_o,
  output logic [SPW-1:0] sp_o,
  output logic           bsy_o,
  output logic           ovf_o,
  output logic           unf_o
);

  localparam int AW = SPW - 1;

  ss_state_t      r_state, w_state_nxt;
  logic [DSZ-1:0] r_s, w_s_nxt;
  logic [SPW-1:0] r_sp, w_sp_nxt;
  logic           r_ovf, r_unf;
  logic           w_ovf_set, w_unf_set;
  logic           w_we;
  logic [AW-1:0]  w_addr;
  logic [DSZ-1:0] w_rd;
  ss_op_t         w_op;

  ej32_ss_ram #(
    .SS_DEPTH (SS_DEPTH),
    .DSZ      (DSZ)
  ) u_ram (
    .clk  (clk),
    .we   (w_we),
    .addr (w_addr),
    .wd   (r_s),
    .rd   (w_rd)
  );

  // Next-state, depth, NOS and RAM-port decode.
  // RAM addresses use the low AW bits of d: modulo arithmetic gives the
  // right index even when d = SS_DEPTH (its low bits are zero).
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_sp_nxt    = r_sp;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_op        = en ? ss_op : sNOP;

    unique case (r_state)
      ST_FILL: begin
        w_s_nxt     = w_rd;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        unique case (w_op)
          sPUSH: begin
            if (r_sp == SPW'(SS_DEPTH)) begin
              w_ovf_set = 1'b1;
            end else if (r_sp == '0) begin
              w_s_nxt  = t;
              w_sp_nxt = SPW'(1);
            end else begin
              w_we     = 1'b1;
              w_addr   = r_sp[AW-1:0] - AW'(1);
              w_s_nxt  = t;
              w_sp_nxt = r_sp + SPW'(1);
            end
          end
          sPOP: begin
            if (r_sp == '0) begin
              w_unf_set = 1'b1;
            end else if (r_sp == SPW'(1)) begin
              w_s_nxt  = '0;
              w_sp_nxt = '0;
            end else begin
              w_addr      = r_sp[AW-1:0] - AW'(2);
              w_sp_nxt    = r_sp - SPW'(1);
              w_state_nxt = ST_FILL;
            end
          end
          sMOVE: begin
            if (r_sp == '0) w_unf_set = 1'b1;
            else            w_s_nxt   = t;
          end
          default: ;
        endcase
      end
    endcase
  end

  // State, depth and NOS registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~clr_err) | w_ovf_set;
      r_unf <= (r_unf & ~clr_err) | w_unf_set;
    end
  end

  assign s_o   = r_s;
  assign sp_o  = r_sp;
  assign bsy_o = (r_state == ST_FILL);
  assign ovf_o = r_ovf;
  assign unf_o = r_unf;

endmodule
